// File: rtl/rsa_core_arbiter_if.sv
// rtl/rsa_core_arbiter_if.sv - operand/result bus between the arbiter (master) and the shared RSA core (slave)
interface rsa_core_arbiter_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] result;
    logic             finished;

    modport master (output start, a, e, n, input result, finished);
    modport slave  (input start, a, e, n, output result, finished);
endinterface

// File: rtl/rsa_core_arbiter.sv
// rtl/rsa_core_arbiter.sv - round-robin sharing of one RSA core between two requesters
// Optional per-requester job counters o_jobs0/o_jobs1 when RSA_ARB_STATS_EN is defined.
module rsa_core_arbiter #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_e0,
    input  logic [WIDTH-1:0] i_n0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_e1,
    input  logic [WIDTH-1:0] i_n1,
    output logic             o_ack0,
    output logic             o_ack1,
    output logic             o_done0,
    output logic             o_done1,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    rsa_core_arbiter_if.master core
`ifdef RSA_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] o_jobs0,
    output logic [CNT_W-1:0] o_jobs1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   owner_q;
    logic   rr_q;
    logic   grant;
    logic   grant_owner;
    logic   ack0_d, ack1_d, done0_d, done1_d, busy_d;

    // With both requesting, the round-robin pointer decides; otherwise the lone requester wins.
    assign grant       = (state_q == S_IDLE) && (i_req0 || i_req1);
    assign grant_owner = (i_req0 && i_req1) ? rr_q : i_req1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_req0 || i_req1) state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY:  if (core.finished) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with the state they describe.
    always_comb begin
        ack0_d  = grant && !grant_owner;
        ack1_d  = grant && grant_owner;
        done0_d = (state_d == S_DONE) && !owner_q;
        done1_d = (state_d == S_DONE) && owner_q;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_done0    <= 1'b0;
            o_done1    <= 1'b0;
            o_busy     <= 1'b0;
            o_result   <= '0;
            core.start <= 1'b0;
            core.a     <= '0;
            core.e     <= '0;
            core.n     <= '0;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            o_ack0     <= ack0_d;
            o_ack1     <= ack1_d;
            o_done0    <= done0_d;
            o_done1    <= done1_d;
            o_busy     <= busy_d;
            core.start <= grant;
            if (grant) begin
                owner_q <= grant_owner;
                core.a  <= grant_owner ? i_a1 : i_a0;
                core.e  <= grant_owner ? i_e1 : i_e0;
                core.n  <= grant_owner ? i_n1 : i_n0;
            end
            if (state_q == S_BUSY && core.finished) begin
                o_result <= core.result;
            end
            if (state_q == S_DONE) begin
                rr_q <= ~owner_q;
            end
        end
    end

`ifdef RSA_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_jobs0 <= '0;
            o_jobs1 <= '0;
        end else begin
            if (o_done0 && (o_jobs0 != {CNT_W{1'b1}})) o_jobs0 <= o_jobs0 + 1'b1;
            if (o_done1 && (o_jobs1 != {CNT_W{1'b1}})) o_jobs1 <= o_jobs1 + 1'b1;
        end
    end
`else
    // CNT_W only sizes the job counters, which are absent in this build.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
